// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with a valid/ready load handshake and a per-bit strobe.
// Bit order is LSB first by default; define PISO_MSB_FIRST_EN for MSB first.
module piso_serializer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ena,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_en,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             last_bit;
  logic             load;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      shreg <= shreg_nxt;
      cnt   <= cnt_nxt;
      done  <= last_bit;
    end
  end

  // The last-bit cycle reopens the handshake so a new word follows with no gap.
  always_comb begin
    last_bit   = (state == SHIFT) && ena && (cnt == CW'(1));
    load_ready = (state == IDLE) || last_bit;
    load       = load_ready && load_valid;
    serial_en  = (state == SHIFT) && ena;
    busy       = (state == SHIFT);
    state_nxt  = state;
    shreg_nxt  = shreg;
    cnt_nxt    = cnt;
    if (load) begin
      state_nxt = SHIFT;
      shreg_nxt = load_data;
      cnt_nxt   = CW'(WIDTH);
    end else if (serial_en) begin
`ifdef PISO_MSB_FIRST_EN
      shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
`else
      shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
`endif
      cnt_nxt   = cnt - CW'(1);
      if (last_bit) state_nxt = IDLE;
    end
  end

  always_comb begin
    serial_out = 1'b0;
    if (state == SHIFT) begin
`ifdef PISO_MSB_FIRST_EN
      serial_out = shreg[WIDTH-1];
`else
      serial_out = shreg[0];
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Table-driven bench for piso_serializer with a SIPO receiver model on the serial link.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       clr_n = 1'b0;
  logic       ena = 1'b0;
  logic       load_valid = 1'b0;
  logic [3:0] load_data = '0;
  logic       load_ready, serial_out, serial_en, busy, done;
  logic [3:0] rx = '0;

  int errors = 0;
  int checks = 0;

  piso_serializer #(.WIDTH(4)) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .ena        (ena),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .serial_out (serial_out),
    .serial_en  (serial_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Receiver: LSB-first shift-in on each strobed bit.
  always @(posedge clk) if (serial_en) rx <= {serial_out, rx[3:1]};

  // Expected {serial_out, serial_en, busy, done, load_ready} and optional receiver word.
  typedef struct {
    logic       e;
    logic       lv;
    logic [3:0] d;
    logic [4:0] exp;
    logic       chk_rx;
    logic [3:0] exp_rx;
  } vec_t;

  vec_t vq[$];

  // Output order of word 4'b1000: bit i is the value in shift cycle i+1.
`ifdef PISO_MSB_FIRST_EN
  logic [3:0] s1000 = 4'b0001;
`else
  logic [3:0] s1000 = 4'b1000;
`endif

  function automatic void add(logic e, logic lv, logic [3:0] d, logic [4:0] exp,
                              logic chk_rx, logic [3:0] exp_rx);
    vec_t v;
    v.e = e; v.lv = lv; v.d = d; v.exp = exp; v.chk_rx = chk_rx; v.exp_rx = exp_rx;
    vq.push_back(v);
  endfunction

  task automatic chk(string name, logic [4:0] act, logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: {so,sen,busy,done,rdy} got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_rx(string name, logic [3:0] exp);
    checks++;
    if (rx !== exp) begin
      errors++;
      $display("FAIL %s: receiver word got %b expected %b", name, rx, exp);
    end
  endtask

  task automatic run_vecs(string tag);
    for (int unsigned i = 0; i < vq.size(); i++) begin
      ena = vq[i].e;
      load_valid = vq[i].lv;
      load_data = vq[i].d;
      #1;
      chk($sformatf("%s row %0d", tag, i),
          {serial_out, serial_en, busy, done, load_ready}, vq[i].exp);
      if (vq[i].chk_rx) chk_rx($sformatf("%s rx row %0d", tag, i), vq[i].exp_rx);
      @(posedge clk);
      #1;
    end
    vq.delete();
  endtask

  initial begin
    ena = 1'b1;
    #2;
    chk("reset outputs", {serial_out, serial_en, busy, done, load_ready}, 5'b00001);
    @(posedge clk);
    #1;
    clr_n = 1'b1;

`ifndef PISO_MSB_FIRST_EN
    // 1011 with ena held high
    add(1, 1, 4'b1011, 5'b00001, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11101, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b00011, 1, 4'b1011);
    add(1, 0, 4'b0000, 5'b00001, 0, 4'b0000);
    // 0110 with ena toggling
    add(1, 1, 4'b0110, 5'b00001, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01100, 0, 4'b0000);
    add(0, 0, 4'b0000, 5'b10100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11100, 0, 4'b0000);
    add(0, 0, 4'b0000, 5'b10100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11100, 0, 4'b0000);
    add(0, 0, 4'b0000, 5'b00100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01101, 0, 4'b0000);
    add(0, 0, 4'b0000, 5'b00011, 1, 4'b0110);
    // back-to-back 1100 then 0011
    add(1, 1, 4'b1100, 5'b00001, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11100, 0, 4'b0000);
    add(1, 1, 4'b0011, 5'b11101, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11110, 1, 4'b1100);
    add(1, 0, 4'b0000, 5'b11100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01101, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b00011, 1, 4'b0011);
    // 0001 with an ignored load attempt on bit 2
    add(1, 1, 4'b0001, 5'b00001, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11100, 0, 4'b0000);
    add(1, 1, 4'b1111, 5'b01100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01101, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b00011, 1, 4'b0001);
    add(1, 0, 4'b0000, 5'b00001, 0, 4'b0000);
    run_vecs("main");
`endif

    // 1000: bit order depends on the build, timing does not
    add(1, 1, 4'b1000, 5'b00001, 0, 4'b0000);
    add(1, 0, 4'b0000, {s1000[0], 4'b1100}, 0, 4'b0000);
    add(1, 0, 4'b0000, {s1000[1], 4'b1100}, 0, 4'b0000);
    add(1, 0, 4'b0000, {s1000[2], 4'b1100}, 0, 4'b0000);
    add(1, 0, 4'b0000, {s1000[3], 4'b1101}, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b00011, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b00001, 0, 4'b0000);
    run_vecs("w1000");

`ifndef PISO_MSB_FIRST_EN
    // reset after two bits of 1010
    add(1, 1, 4'b1010, 5'b00001, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11100, 0, 4'b0000);
    run_vecs("pre-reset");
    #1;
    chk("mid-frame bit 3", {serial_out, serial_en, busy, done, load_ready}, 5'b01100);
    clr_n = 1'b0;
    #1;
    chk("async reset", {serial_out, serial_en, busy, done, load_ready}, 5'b00001);
    @(posedge clk);
    #1;
    chk("held reset", {serial_out, serial_en, busy, done, load_ready}, 5'b00001);
    clr_n = 1'b1;
    add(1, 0, 4'b0000, 5'b00001, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b00001, 0, 4'b0000);
    add(1, 1, 4'b0101, 5'b00001, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b11100, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b01101, 0, 4'b0000);
    add(1, 0, 4'b0000, 5'b00011, 1, 4'b0101);
    add(1, 0, 4'b0000, 5'b00001, 0, 4'b0000);
    run_vecs("post-reset");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out transmitter for the 4-bit serial link. It accepts a WIDTH-bit word through a valid/ready load handshake and shifts it out one bit per enabled clock, LSB first. It drives a per-bit strobe, so the team's SIPO receiver reconstructs the original word when its `ena` is tied to `serial_en` and its `data_in` to `serial_out`. The block sits on the transmit side of the ParaleloSerie link, between the parallel data source and the serial wire.

## Interface
- `WIDTH`, default 4: word length in bits. Must be at least 2.
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `clr_n` input, 1 bit: asynchronous, active-low reset.
- `ena` input, 1 bit: bit-rate strobe; one bit advances per clock with `ena`=1.
- `load_valid` input, 1 bit: `load_data` is valid.
- `load_data` input, WIDTH bits: parallel word to transmit.
- `load_ready` output, 1 bit: a word can be accepted this cycle.
- `serial_out` output, 1 bit: current serial bit.
- `serial_en` output, 1 bit: `serial_out` is a valid bit to be sampled at this edge.
- `busy` output, 1 bit: a frame is in progress.
- `done` output, 1 bit: one-cycle pulse after the last bit of a frame is consumed.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: a frame is being transmitted.
- Internal state:
  - Shift register `shreg` [WIDTH-1:0].
  - Bit counter `cnt`, width $clog2(WIDTH+1).
- IDLE behaviour:
  - `load_ready`=1.
  - `load_valid`=1 captures `load_data` into `shreg`, sets `cnt`=WIDTH and moves to SHIFT.
- SHIFT behaviour:
  - `serial_out`=`shreg[0]`.
  - `serial_en`=`ena` (combinational AND with the SHIFT state).
  - On each edge with `ena`=1: `shreg` shifts right with 0 filled at the MSB, and `cnt` decrements.
  - `ena`=0 holds all state; the bit stays on `serial_out`.
- Last bit (`cnt`==1 and `ena`=1):
  - `load_ready`=1 combinationally.
  - If `load_valid`=1: load the new word, set `cnt`=WIDTH, stay in SHIFT. There is no idle gap between frames.
  - Otherwise go to IDLE.
  - In both cases `done`=1 on the following cycle.
- `load_valid` in SHIFT outside the last-bit cycle is ignored. `load_ready`=0 there, and the word is not captured.
- `busy`=1 exactly while in SHIFT.
- `serial_out`=0 in IDLE.
- `done` is registered and lasts exactly one cycle per completed frame.

## Timing
- Reset (`clr_n`=0, asynchronous) forces, immediately:
  - state IDLE, `shreg`=0, `cnt`=0;
  - `done`=0, `busy`=0, `serial_out`=0, `serial_en`=0, `load_ready`=1.
- Reset mid-frame aborts the frame. No `done` pulse is produced, and no partial bits follow after release.
- Load latency: handshake at edge E0; first bit valid on `serial_out` in the cycle after E0.
- With `ena` held at 1, a frame occupies exactly WIDTH cycles.
- `done` is high in the cycle after the edge that consumed the final bit.
- Continuous back-to-back frames give a throughput of 1 bit/cycle.
- `serial_out`, `busy` and `done` are registered or state-decoded.
- `load_ready` and `serial_en` are combinational from state, `cnt` and `ena`. There is no combinational path from `load_valid`.

## Configuration
- Macro `PISO_MSB_FIRST_EN`.
- Undefined (default):
  - LSB first: `serial_out`=`shreg[0]`, shift right.
  - Matches the SIPO receiver.
- Defined:
  - MSB first: `serial_out`=`shreg[WIDTH-1]`, shift left with 0 fill.
  - All handshake, counter and timing behaviour is identical.

## Test plan
- Reset, then load 4'b1011 with `ena`=1 constantly:
  - `serial_out` is 1,1,0,1 on 4 consecutive cycles with `serial_en`=1.
  - `done` pulses once.
  - A SIPO receiver on the link outputs 4'b1011.
- Load 4'b0110 with `ena` toggling 1,0,1,0,…:
  - Each bit is held through `ena`=0 cycles.
  - `serial_en` pulses exactly 4 times.
  - The receiver outputs 4'b0110.
  - `done` comes 8 cycles after the load.
- Back-to-back frames: 4'b1100, then 4'b0011 presented on the last-bit cycle:
  - 8 contiguous bits 0,0,1,1,1,1,0,0.
  - `busy` never drops.
  - Two `done` pulses.
- `load_valid` with 4'b1111 asserted during bit 2 of frame 4'b0001:
  - Word ignored; `load_ready`=0.
  - The output stream remains 1,0,0,0.
- `clr_n` pulsed low after 2 bits of 4'b1010:
  - All outputs reset immediately.
  - No `done` pulse.
  - The next load of 4'b0101 transmits cleanly as 1,0,1,0.
- With `PISO_MSB_FIRST_EN` defined, load 4'b1000:
  - Stream is 1,0,0,0, MSB first.
  - Timing is identical to the default build.
